// File: rtl/srl_fifo.sv
// Shift-register FIFO with first-word-fall-through output, occupancy count,
// almost-full flag and sticky overflow/underflow error flags.
module srl_fifo #(
    parameter int WID   = 8,
    parameter int DEP   = 16,
    parameter int AFULL = DEP - 2,
    localparam int CW   = $clog2(DEP + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr,
    input  logic [WID-1:0] d,
    input  logic           rd,
    output logic [WID-1:0] q,
    output logic           empty,
    output logic           full,
    output logic           afull,
    output logic [CW-1:0]  cnt,
    output logic           ovf,
    output logic           unf
);

    localparam int AW = $clog2(DEP);

    logic [WID-1:0] mem [DEP];
    logic           rd_acc;
    logic           wr_acc;
    logic [AW-1:0]  head_idx;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEP));
    assign afull = (cnt >= CW'(AFULL));

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = rd & ~empty;
    assign wr_acc = wr & (~full | rd_acc);

    // Newest word sits at entry 0, so the oldest is at entry cnt-1.
    assign head_idx = AW'(cnt - CW'(1));
    assign q        = empty ? '0 : mem[head_idx];

    // NOTE: storage has no reset; cnt alone decides which entries are valid,
    // which keeps the array a plain shift register with only an enable.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[0] <= d;
            for (int i = 1; i < DEP; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (wr && !wr_acc) ovf <= 1'b1;
            if (rd && empty)   unf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_srl_fifo.sv
// Directed and model-checked stimulus for srl_fifo at default parameters
// (WID=8, DEP=16, AFULL=14).
module tb_srl_fifo;

    localparam int WID   = 8;
    localparam int DEP   = 16;
    localparam int AFULL = DEP - 2;
    localparam int CW    = $clog2(DEP + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           wr  = 1'b0;
    logic           rd  = 1'b0;
    logic [WID-1:0] d   = '0;
    logic [WID-1:0] q;
    logic           empty, full, afull, ovf, unf;
    logic [CW-1:0]  cnt;

    int n_vec = 0;
    int n_err = 0;

    srl_fifo #(.WID(WID), .DEP(DEP), .AFULL(AFULL)) dut (
        .clk(clk), .rst(rst), .wr(wr), .d(d), .rd(rd), .q(q),
        .empty(empty), .full(full), .afull(afull), .cnt(cnt),
        .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply the currently driven inputs at one rising edge; outputs settle by #1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr = 1'b0; rd = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [WID-1:0] v);
        wr = 1'b1; rd = 1'b0; d = v;
        tick();
        wr = 1'b0;
    endtask

    task automatic pop();
        wr = 1'b0; rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < DEP; i++) push(WID'(i));
    endtask

    logic [WID-1:0] model[$];
    logic           m_ovf, m_unf;

    initial begin
        #2;
        do_reset();
        chk("rst_cnt",   32'(cnt),   0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full",  32'(full),  0);
        chk("rst_afull", 32'(afull), 0);
        chk("rst_q",     32'(q),     0);
        chk("rst_ovf",   32'(ovf),   0);
        chk("rst_unf",   32'(unf),   0);

        // Basic write then drain.
        push(8'h11); push(8'h22); push(8'h33);
        chk("w3_cnt", 32'(cnt), 3);
        chk("w3_q",   32'(q),   32'h11);
        pop(); chk("r1_q", 32'(q), 32'h22);
        pop(); chk("r2_q", 32'(q), 32'h33);
        pop(); chk("r3_q", 32'(q), 32'h00);
        chk("r3_empty", 32'(empty), 1);
        chk("r3_ovf",   32'(ovf),   0);
        chk("r3_unf",   32'(unf),   0);

        // Fill to full, watching afull threshold, then overflow.
        for (int i = 0; i < DEP; i++) begin
            push(WID'(i));
            chk("fill_afull", 32'(afull), 32'(i + 1 >= AFULL));
            chk("fill_full",  32'(full),  32'(i + 1 == DEP));
        end
        chk("full_cnt", 32'(cnt), DEP);
        chk("full_q",   32'(q),   0);
        push(8'hFF);
        chk("ovf_cnt",  32'(cnt), DEP);
        chk("ovf_q",    32'(q),   0);
        chk("ovf_set",  32'(ovf), 1);
        for (int i = 0; i < DEP; i++) begin
            chk("ovf_drain_q", 32'(q), 32'(i));
            pop();
        end
        chk("ovf_drain_empty", 32'(empty), 1);
        chk("ovf_sticky",      32'(ovf),   1);

        // Simultaneous read and write at full.
        do_reset();
        fill_ramp();
        wr = 1'b1; rd = 1'b1; d = 8'hAA;
        tick();
        wr = 1'b0; rd = 1'b0;
        chk("rw_full_cnt", 32'(cnt), DEP);
        chk("rw_full_q",   32'(q),   1);
        chk("rw_full_ovf", 32'(ovf), 0);
        for (int i = 2; i < DEP; i++) begin
            pop();
            chk("rw_drain_q", 32'(q), 32'(i));
        end
        pop();
        chk("rw_last_q", 32'(q), 32'hAA);
        pop();
        chk("rw_end_empty", 32'(empty), 1);

        // Read on empty with a concurrent write.
        do_reset();
        wr = 1'b1; rd = 1'b1; d = 8'h5C;
        tick();
        wr = 1'b0; rd = 1'b0;
        chk("unf_set", 32'(unf), 1);
        chk("unf_cnt", 32'(cnt), 1);
        chk("unf_q",   32'(q),   32'h5C);

        // Read+write at cnt=1 shows the new word; at cnt=2 the second-oldest.
        wr = 1'b1; rd = 1'b1; d = 8'h77;
        tick();
        chk("rw_k1_q",   32'(q),   32'h77);
        chk("rw_k1_cnt", 32'(cnt), 1);
        wr = 1'b0; rd = 1'b0;
        push(8'h88);
        wr = 1'b1; rd = 1'b1; d = 8'h99;
        tick();
        wr = 1'b0; rd = 1'b0;
        chk("rw_k2_q",   32'(q),   32'h88);
        chk("rw_k2_cnt", 32'(cnt), 2);

        // Reset wins over wr/rd at cnt=5 with ovf set.
        do_reset();
        fill_ramp();
        push(8'hEE);
        for (int i = 0; i < DEP - 5; i++) pop();
        chk("pre_rst_cnt", 32'(cnt), 5);
        chk("pre_rst_ovf", 32'(ovf), 1);
        rst = 1'b1; wr = 1'b1; rd = 1'b1; d = 8'h42;
        tick();
        rst = 1'b0; wr = 1'b0; rd = 1'b0;
        chk("rst_pri_cnt",   32'(cnt),   0);
        chk("rst_pri_empty", 32'(empty), 1);
        chk("rst_pri_ovf",   32'(ovf),   0);
        chk("rst_pri_unf",   32'(unf),   0);
        chk("rst_pri_q",     32'(q),     0);

        // Random traffic against a queue model, bias changing every 500 cycles.
        do_reset();
        model.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            int  wr_pct;
            int  sz;
            bit  m_rd, m_wr;
            wr_pct = ((c / 500) % 3 == 0) ? 80 : (((c / 500) % 3 == 1) ? 20 : 50);
            wr = ($urandom_range(99) < 32'(wr_pct));
            rd = ($urandom_range(99) < 32'(100 - wr_pct));
            d  = WID'($urandom);
            sz = model.size();
            m_rd = rd && (sz > 0);
            m_wr = wr && ((sz < DEP) || m_rd);
            if (wr && !m_wr)   m_ovf = 1'b1;
            if (rd && sz == 0) m_unf = 1'b1;
            tick();
            if (m_rd) void'(model.pop_front());
            if (m_wr) model.push_back(d);
            sz = model.size();
            chk("rnd_q",     32'(q),     (sz > 0) ? 32'(model[0]) : 0);
            chk("rnd_cnt",   32'(cnt),   32'(sz));
            chk("rnd_empty", 32'(empty), 32'(sz == 0));
            chk("rnd_full",  32'(full),  32'(sz == DEP));
            chk("rnd_afull", 32'(afull), 32'(sz >= AFULL));
            chk("rnd_ovf",   32'(ovf),   32'(m_ovf));
            chk("rnd_unf",   32'(unf),   32'(m_unf));
        end
        wr = 1'b0; rd = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/srl_fifo.md
SRL_FIFO -- requirements
Module: srl_fifo

Interface
REQ-001 SHALL have parameter WID, default 8, data word width in bits.
REQ-002 SHALL have parameter DEP, default 16, storage depth in words (power of two, >= 2).
REQ-003 SHALL have parameter AFULL, default DEP-2, almost-full threshold in words (1..DEP).
REQ-004 SHALL define localparam CW = $clog2(DEP+1), the occupancy count width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 wr  input  1  write request.
REQ-008 d  input  WID  write data.
REQ-009 rd  input  1  read request (pop head word).
REQ-010 q  output  WID  head word, first-word-fall-through.
REQ-011 empty  output  1  occupancy == 0.
REQ-012 full  output  1  occupancy == DEP.
REQ-013 afull  output  1  occupancy >= AFULL.
REQ-014 cnt  output  CW  current occupancy, 0..DEP.
REQ-015 ovf  output  1  sticky overflow error.
REQ-016 unf  output  1  sticky underflow error.

Function
REQ-017 SHALL store words in an internal shift array of DEP x WID, shifted by one entry (new word at entry 0) only on an accepted write; entries are not reset.
REQ-018 SHALL accept a read as rd_acc = rd & ~empty.
REQ-019 SHALL accept a write as wr_acc = wr & (~full | rd_acc), so a full FIFO accepts a write in the same cycle as an accepted read.
REQ-020 SHALL update cnt at each edge to cnt + wr_acc - rd_acc; no change when both or neither are accepted.
REQ-021 SHALL drive q combinationally from entry cnt-1 (oldest word) when cnt != 0, and drive all zeros when cnt == 0.
REQ-022 SHALL provide zero-latency read: a word written at edge N appears on q after edge N when the FIFO was empty.
REQ-023 SHALL derive empty, full and afull combinationally from cnt only.
REQ-024 SHALL on simultaneous accepted read and write at cnt == k (k >= 1) present the word formerly at position 2 (old entry k-2) on q after the edge when k >= 2, or the newly written word when k == 1.
REQ-025 SHALL set ovf at the edge where wr=1 and the write is not accepted; ovf stays set until reset.
REQ-026 SHALL set unf at the edge where rd=1 and empty=1; unf stays set until reset.
REQ-027 SHALL ignore the request that is rejected without changing cnt or storage (a rejected write does not shift; a rejected read does not decrement).
REQ-028 SHALL never let cnt wrap past DEP or below 0.

Reset
REQ-029 SHALL, on a rising edge with rst=1, set cnt=0, ovf=0, unf=0, giving empty=1, full=0, afull=0 (AFULL >= 1), q=0 after that edge.
REQ-030 SHALL give rst priority over wr and rd in the same cycle: no write is accepted, no flag is set, and storage contents are don't-care.
REQ-031 SHALL allow normal operation from the first edge after rst deasserts.

Verification
REQ-032 Reset then write 0x11,0x22,0x33 on consecutive cycles -> cnt=3, q=0x11; three reads -> q=0x22, 0x33, then 0x00 with empty=1; ovf=unf=0.
REQ-033 Write DEP words 0..DEP-1 -> full=1, afull=1 from cnt=AFULL, cnt=DEP; one more wr -> cnt stays DEP, storage unchanged, ovf=1 and stays 1.
REQ-034 At full (q=0x00), wr=rd=1 with d=0xAA -> cnt stays DEP, q=0x01, ovf=0; draining shows 0xAA last.
REQ-035 Empty FIFO, rd=1 -> unf=1, cnt=0; same cycle wr=1 d=0x5C -> write accepted, cnt=1, q=0x5C.
REQ-036 cnt=5 with ovf=1, assert rst with wr=rd=1 -> after edge cnt=0, empty=1, ovf=unf=0, q=0.
REQ-037 Random wr/rd stimulus against a reference queue model for 10000 cycles -> q, cnt and flags match every cycle.
